// File: rtl/pipe_hazard_scoreboard.sv
// Issue-stage hazard controller for the F/D/I/E/M/W pipeline.
// Tracks pending register writes, stalls F/D/I on RAW hazards and sequences
// the branch-taken flush.
//
// Optional build macro: HAZARD_LOADUSE_ONLY_EN
//   When defined, adds input m_memread_e and stalls only on single-cycle
//   load-use (source == e_dst while EX is a load). The scoreboard is still kept.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_valid                  issue stage holds a real instruction
//   i_rs/i_rt, i_use_rs/rt   source registers and their use flags
//   i_regwrite, i_dst        issuing instruction's destination
//   e_regwrite, e_dst        EX-stage destination (squashed on flush)
//   w_regwrite, w_dst        writeback this cycle
//   pc_src                   branch taken, resolved in M
//   m_memread_e              (macro only) EX instruction is a load
//   stall_fd                 hold PC, IFID and IDIS (combinational)
//   bubble_i                 load NOP controls into ISEX (combinational)
//   flush_fd                 clear IFID, IDIS, ISEX at next edge (combinational)
//   pending                  bit r set while register r has writes in flight
//   stall_cnt                saturating count of stall_fd cycles
module pipe_hazard_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [4:0]      i_rs,
  input  logic [4:0]      i_rt,
  input  logic            i_use_rs,
  input  logic            i_use_rt,
  input  logic            i_regwrite,
  input  logic [4:0]      i_dst,
  input  logic            e_regwrite,
  input  logic [4:0]      e_dst,
  input  logic            w_regwrite,
  input  logic [4:0]      w_dst,
  input  logic            pc_src,
`ifdef HAZARD_LOADUSE_ONLY_EN
  input  logic            m_memread_e,
`endif
  output logic            stall_fd,
  output logic            bubble_i,
  output logic            flush_fd,
  output logic [NREG-1:0] pending,
  output logic [15:0]     stall_cnt
);

  localparam int unsigned FCNT_W    = 3;
  localparam int          CNT_MAX_I = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e              state_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [CNT_W-1:0]    cnt_q [NREG];
  logic [CNT_W-1:0]    cnt_d [NREG];
  logic [15:0]         stall_cnt_q;

  logic                hazard;
  logic                fire;
  logic                range_err;
  logic [CNT_W-1:0]    rs_cnt;
  logic [CNT_W-1:0]    rt_cnt;
  logic                rs_busy;
  logic                rt_busy;

  // Source busy test; a sole in-flight write retiring this cycle is bypassed
  // by the register bank's write-through.
  always_comb begin
    rs_cnt  = cnt_q[i_rs];
    rt_cnt  = cnt_q[i_rt];
    rs_busy = i_use_rs && (i_rs != 5'd0) && (rs_cnt != '0) &&
              !(w_regwrite && (w_dst == i_rs) && (rs_cnt == CNT_ONE));
    rt_busy = i_use_rt && (i_rt != 5'd0) && (rt_cnt != '0) &&
              !(w_regwrite && (w_dst == i_rt) && (rt_cnt == CNT_ONE));
`ifdef HAZARD_LOADUSE_ONLY_EN
    // ALU results are forwarded; only a load in EX cannot be bypassed in time.
    hazard = m_memread_e &&
             ((i_use_rs && (i_rs != 5'd0) && (i_rs == e_dst)) ||
              (i_use_rt && (i_rt != 5'd0) && (i_rt == e_dst)));
`else
    hazard = rs_busy || rt_busy;
`endif
  end

  // Pipeline control; a taken branch overrides any stall.
  always_comb begin
    flush_fd = !rst && pc_src;
    stall_fd = !rst && (state_q == S_RUN) && !pc_src && i_valid && hazard;
    bubble_i = !rst && ((state_q == S_FLUSH) || stall_fd);
    fire     = (state_q == S_RUN) && i_valid && !hazard && !pc_src;
  end

  // Per-register count update: issue increments, writeback and flush squash
  // decrement; an out-of-range result holds the old value.
  always_comb begin
    range_err = 1'b0;
    for (int r = 0; r < int'(NREG); r++) begin
      logic inc;
      logic dec_w;
      logic dec_e;
      int   nxt;
      cnt_d[r] = cnt_q[r];
      inc   = fire && i_regwrite && (i_dst == 5'(r)) && (r != 0);
      dec_w = w_regwrite && (w_dst == 5'(r)) && (r != 0);
      dec_e = pc_src && e_regwrite && (e_dst == 5'(r)) && (r != 0);
      nxt   = int'(cnt_q[r]) + (inc ? 1 : 0) - (dec_w ? 1 : 0) - (dec_e ? 1 : 0);
      if ((nxt < 0) || (nxt > CNT_MAX_I)) begin
        range_err = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(nxt);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  assign stall_cnt = stall_cnt_q;

  // Scoreboard, flush sequencer and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (stall_fd && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      case (state_q)
        S_RUN: begin
          if (pc_src) begin
            state_q <= S_FLUSH;
            fcnt_q  <= FCNT_LOAD;
          end
        end
        S_FLUSH: begin
          if (pc_src) begin
            fcnt_q <= FCNT_LOAD;
          end else if (fcnt_q == '0) begin
            state_q <= S_RUN;
          end else begin
            fcnt_q <= fcnt_q - FCNT_W'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // A counter leaving its range means the pipeline and scoreboard disagree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!range_err)
        else $error("pipe_hazard_scoreboard: pending counter out of range");
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
module tb_pipe_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_use_rs, i_use_rt, i_regwrite;
  logic [4:0]  i_rs, i_rt, i_dst;
  logic        e_regwrite, w_regwrite, pc_src;
  logic [4:0]  e_dst, w_dst;
`ifdef HAZARD_LOADUSE_ONLY_EN
  logic        m_memread_e;
`endif
  logic        stall_fd, bubble_i, flush_fd;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .i_use_rs   (i_use_rs),
    .i_use_rt   (i_use_rt),
    .i_regwrite (i_regwrite),
    .i_dst      (i_dst),
    .e_regwrite (e_regwrite),
    .e_dst      (e_dst),
    .w_regwrite (w_regwrite),
    .w_dst      (w_dst),
    .pc_src     (pc_src),
`ifdef HAZARD_LOADUSE_ONLY_EN
    .m_memread_e(m_memread_e),
`endif
    .stall_fd   (stall_fd),
    .bubble_i   (bubble_i),
    .flush_fd   (flush_fd),
    .pending    (pending),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic rw,
                           input logic [4:0] dst);
    i_valid = v; i_rs = rs; i_rt = rt; i_use_rs = urs; i_use_rt = urt;
    i_regwrite = rw; i_dst = dst;
    #1;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] dst);
    w_regwrite = rw; w_dst = dst;
    #1;
  endtask

  task automatic set_br(input logic br, input logic erw, input logic [4:0] edst);
    pc_src = br; e_regwrite = erw; e_dst = edst;
    #1;
  endtask

  task automatic clear_all();
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_wb(1'b0, 5'd0);
    set_br(1'b0, 1'b0, 5'd0);
  endtask

  // Asynchronous reset pulse placed mid-cycle.
  task automatic pulse_reset();
    clear_all();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
`ifdef HAZARD_LOADUSE_ONLY_EN
    m_memread_e = 1'b0;
`endif
    clear_all();
    // Reset state; a branch request during reset must not flush.
    set_br(1'b1, 1'b1, 5'd7);
    check("rst_flush", 32'(flush_fd), 32'd0);
    check("rst_stall", 32'(stall_fd), 32'd0);
    check("rst_bubble", 32'(bubble_i), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    set_br(1'b0, 1'b0, 5'd0);
    #2;
    rst = 1'b0;
    tick();

    // 1: addi $10 then dependent add $10,$10,$11.
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10);
    check("t1_addi_nostall", 32'(stall_fd), 32'd0);
    tick();
    set_issue(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 5'd10);
    check("t1_stall_c1", 32'(stall_fd), 32'd1);
    check("t1_bubble_c1", 32'(bubble_i), 32'd1);
    check("t1_pending_c1", pending, 32'h0000_0400);
    tick();
    check("t1_stall_c2", 32'(stall_fd), 32'd1);
    tick();
    check("t1_stall_c3", 32'(stall_fd), 32'd1);
    tick();
    set_wb(1'b1, 5'd10);
    check("t1_release", 32'(stall_fd), 32'd0);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t1_add_inflight", pending, 32'h0000_0400);
    tick();
    set_wb(1'b0, 5'd0);
    check("t1_pending_clear", pending, 32'd0);

    // 2: independent stream.
    pulse_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(10 + k));
      check("t2_nostall", 32'(stall_fd), 32'd0);
      tick();
    end
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t2_pending_peak", pending, 32'h0000_3C00);
    for (int k = 0; k < 4; k++) begin
      set_wb(1'b1, 5'(10 + k));
      tick();
    end
    set_wb(1'b0, 5'd0);
    check("t2_pending_drain", pending, 32'd0);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd0);

    // 3: saturate count[5] at 3.
    pulse_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
      tick();
    end
    set_issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    set_wb(1'b1, 5'd5);
    check("t3_cnt3_no_bypass", 32'(stall_fd), 32'd1);
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    check("t3_fourth_fires", 32'(stall_fd), 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    set_wb(1'b0, 5'd0);
    check("t3_one_left", pending, 32'h0000_0020);
    set_issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    check("t3_cnt1_stall", 32'(stall_fd), 32'd1);
    set_wb(1'b1, 5'd5);
    check("t3_cnt1_bypass", 32'(stall_fd), 32'd0);
    tick();
    clear_all();
    check("t3_pending_clear", pending, 32'd0);

    // 4: branch taken squashes EX write to $7.
    pulse_reset();
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    check("t4_pending7", pending, 32'h0000_0080);
    set_issue(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
    set_br(1'b1, 1'b1, 5'd7);
    check("t4_flush", 32'(flush_fd), 32'd1);
    check("t4_stall_override", 32'(stall_fd), 32'd0);
    tick();
    set_br(1'b0, 1'b0, 5'd0);
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    check("t4_squash_no_issue", pending, 32'd0);
    check("t4_flush_bubble", 32'(bubble_i), 32'd1);
    check("t4_flush_nostall", 32'(stall_fd), 32'd0);
    check("t4_flush_done", 32'(flush_fd), 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t4_suppressed", pending, 32'd0);
    check("t4_run_bubble", 32'(bubble_i), 32'd0);
    // Back-to-back branches each squash one write to $6.
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_br(1'b1, 1'b1, 5'd6);
    tick();
    check("t4_reflush_pend", pending, 32'h0000_0040);
    check("t4_reflush_flush", 32'(flush_fd), 32'd1);
    tick();
    set_br(1'b0, 1'b0, 5'd0);
    check("t4_reflush_clear", pending, 32'd0);
    check("t4_reflush_bubble", 32'(bubble_i), 32'd1);
    tick();
    check("t4_reflush_run", 32'(bubble_i), 32'd0);

    // 5: asynchronous reset mid-stall.
    pulse_reset();
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    tick();
    set_issue(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    check("t5_stall", 32'(stall_fd), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_stall", 32'(stall_fd), 32'd0);
    check("t5_rst_bubble", 32'(bubble_i), 32'd0);
    check("t5_rst_pending", pending, 32'd0);
    check("t5_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    clear_all();
    tick();
    check("t5_after_pending", pending, 32'd0);

    // 6: stall counter saturation.
    pulse_reset();
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    set_issue(1'b1, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0);
    repeat (100) tick();
    check("t6_stall_cnt_100", 32'(stall_cnt), 32'd100);
    repeat (70000) tick();
    check("t6_stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (5) tick();
    check("t6_stall_cnt_hold", 32'(stall_cnt), 32'h0000_FFFF);

`ifdef HAZARD_LOADUSE_ONLY_EN
    // Load-use only: ALU producer forwarded, load producer stalls.
    pulse_reset();
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4);
    tick();
    set_issue(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    set_br(1'b0, 1'b1, 5'd4);
    m_memread_e = 1'b0;
    #1;
    check("lu_alu_nostall", 32'(stall_fd), 32'd0);
    check("lu_pending", pending, 32'h0000_0010);
    m_memread_e = 1'b1;
    #1;
    check("lu_load_stall", 32'(stall_fd), 32'd1);
    m_memread_e = 1'b0;
    clear_all();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
